// File: rtl/ingress_frame_classifier_if.sv
// ---------------------------------------------------------------------------
// ingress_frame_classifier_if
// Purpose : groups the byte-stream ingress handshake and the descriptor
//           handshake of the ingress frame classifier.
// Signals :
//   rx_valid   - rx_data holds a byte this cycle
//   rx_sop     - byte is the first of a frame (qualified by rx_valid)
//   rx_eop     - byte is the last of a frame (qualified by rx_valid)
//   rx_data    - frame byte
//   rx_ready   - classifier accepts a byte this cycle
//   desc_valid - descriptor available
//   desc_ready - downstream queue accepts the descriptor
//   desc_class - traffic class (00 PCF, 01 TT, 11 RC, 10 BE)
//   desc_len   - frame length in 16-byte units, rounded up
// Modports: master = upstream MAC / downstream queue side, slave = classifier
// ---------------------------------------------------------------------------
interface ingress_frame_classifier_if;
  logic       rx_valid;
  logic       rx_sop;
  logic       rx_eop;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       desc_valid;
  logic       desc_ready;
  logic [1:0] desc_class;
  logic [7:0] desc_len;

  modport master (
    output rx_valid, rx_sop, rx_eop, rx_data,
    input  rx_ready,
    input  desc_valid, desc_class, desc_len,
    output desc_ready
  );

  modport slave (
    input  rx_valid, rx_sop, rx_eop, rx_data,
    output rx_ready,
    output desc_valid, desc_class, desc_len,
    input  desc_ready
  );
endinterface

// File: rtl/ingress_frame_classifier.sv
// ---------------------------------------------------------------------------
// ingress_frame_classifier
// Purpose : receives frames byte by byte, classifies each one as PCF, TT,
//           RC or BE from its destination MAC marker and EtherType, and
//           either emits a descriptor (class + length in 16-byte units) or
//           discards the frame with a one-cycle drop pulse and a cause.
// Ports   :
//   clk        - clock, all registers update on its rising edge
//   rst_n      - asynchronous active-low reset
//   bus        - ingress byte stream and descriptor handshake (slave side)
//   cur_state  - timetable state (00 DEF, 01 MAR, 10 PCF, 11 TT)
//   drop       - one-cycle pulse when a frame is discarded
//   drop_cause - 00 runt, 01 MTU, 10 TT window, 11 abort (valid with drop)
// ---------------------------------------------------------------------------
module ingress_frame_classifier #(
  parameter logic [31:0] CT_MARKER = 32'hABADBABE,
  parameter logic [15:0] PCF_ETYPE = 16'h891D,
  parameter int          MIN_BYTES = 64,
  parameter int          MTU_BYTES = 1520
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ingress_frame_classifier_if.slave   bus,
  input  logic [1:0]                  cur_state,
  output logic                        drop,
  output logic [1:0]                  drop_cause
);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD, DESC} state_t;

  localparam logic [10:0] MIN_CNT = 11'(MIN_BYTES);
  localparam logic [10:0] MTU_CNT = 11'(MTU_BYTES);

  localparam logic [1:0] CLS_PCF = 2'b00;
  localparam logic [1:0] CLS_TT  = 2'b01;
  localparam logic [1:0] CLS_RC  = 2'b11;
  localparam logic [1:0] CLS_BE  = 2'b10;

  localparam logic [1:0] CAUSE_RUNT  = 2'b00;
  localparam logic [1:0] CAUSE_MTU   = 2'b01;
  localparam logic [1:0] CAUSE_TTWIN = 2'b10;
  localparam logic [1:0] CAUSE_ABORT = 2'b11;

  state_t      state;
  logic [10:0] count;
  logic        marker_part;
  logic        marker_hit;
  logic        tt_bit;
  logic        etype_hi;
  logic        pcf_hit;
  logic        tt_window;
  logic        desc_valid_q;
  logic [1:0]  desc_class_q;
  logic [7:0]  desc_len_q;

  logic        accept;
  logic        start;
  logic [10:0] byte_idx;
  logic [10:0] count_nxt;
  logic        marker_part_nxt;
  logic        marker_hit_nxt;
  logic        tt_bit_nxt;
  logic        etype_hi_nxt;
  logic        pcf_hit_nxt;
  logic [1:0]  class_nxt;
  logic [11:0] len_sum;
  logic [7:0]  len_nxt;

  assign bus.rx_ready   = (state != DESC);
  assign bus.desc_valid = desc_valid_q;
  assign bus.desc_class = desc_class_q;
  assign bus.desc_len   = desc_len_q;

  assign accept = bus.rx_valid && bus.rx_ready;
  assign start  = accept && bus.rx_sop;

  // Header capture for the byte on the bus. A sop byte always begins a
  // fresh frame at offset 0, so the capture flags start from their clean
  // values instead of the registered ones. The class and length computed
  // here already include the current byte, so eop decisions see them.
  always_comb begin
    byte_idx        = start ? 11'd0 : count;
    count_nxt       = start ? 11'd1 : ((count == 11'h7FF) ? count : count + 11'd1);
    marker_part_nxt = start ? 1'b1 : marker_part;
    marker_hit_nxt  = start ? 1'b0 : marker_hit;
    tt_bit_nxt      = start ? 1'b0 : tt_bit;
    etype_hi_nxt    = start ? 1'b0 : etype_hi;
    pcf_hit_nxt     = start ? 1'b0 : pcf_hit;
    case (byte_idx)
      11'd0:   marker_part_nxt = (bus.rx_data == CT_MARKER[31:24]);
      11'd1:   marker_part_nxt = marker_part_nxt && (bus.rx_data == CT_MARKER[23:16]);
      11'd2:   marker_part_nxt = marker_part_nxt && (bus.rx_data == CT_MARKER[15:8]);
      11'd3:   marker_hit_nxt  = marker_part_nxt && (bus.rx_data == CT_MARKER[7:0]);
      11'd4:   tt_bit_nxt      = bus.rx_data[0];
      11'd12:  etype_hi_nxt    = (bus.rx_data == PCF_ETYPE[15:8]);
      11'd13:  pcf_hit_nxt     = etype_hi_nxt && (bus.rx_data == PCF_ETYPE[7:0]);
      default: ;
    endcase
    if (pcf_hit_nxt) begin
      class_nxt = CLS_PCF;
    end else if (marker_hit_nxt) begin
      class_nxt = tt_bit_nxt ? CLS_TT : CLS_RC;
    end else begin
      class_nxt = CLS_BE;
    end
    len_sum = {1'b0, count_nxt} + 12'd15;
    len_nxt = 8'(len_sum >> 4);
  end

  // Per-frame registers advance on every byte that belongs to a frame under
  // reception; the timetable window is sampled only on the sop byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= 11'd0;
      marker_part <= 1'b0;
      marker_hit  <= 1'b0;
      tt_bit      <= 1'b0;
      etype_hi    <= 1'b0;
      pcf_hit     <= 1'b0;
      tt_window   <= 1'b0;
    end else if (accept && (bus.rx_sop || state == RECV)) begin
      count       <= count_nxt;
      marker_part <= marker_part_nxt;
      marker_hit  <= marker_hit_nxt;
      tt_bit      <= tt_bit_nxt;
      etype_hi    <= etype_hi_nxt;
      pcf_hit     <= pcf_hit_nxt;
      if (bus.rx_sop) begin
        tt_window <= (cur_state == 2'b11);
      end
    end
  end

  // Frame FSM with registered drop and descriptor outputs. Drop checks run
  // in priority order abort, MTU, runt, TT window. Once a frame is dropped
  // the FSM leaves RECV, so a frame can never pulse drop twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      desc_valid_q <= 1'b0;
      desc_class_q <= 2'b00;
      desc_len_q   <= 8'd0;
      drop         <= 1'b0;
      drop_cause   <= 2'b00;
    end else begin
      drop <= 1'b0;
      case (state)
        IDLE, DISCARD: begin
          if (start) begin
            if (bus.rx_eop) begin
              drop       <= 1'b1;
              drop_cause <= CAUSE_RUNT;
              state      <= IDLE;
            end else begin
              state <= RECV;
            end
          end else if (state == DISCARD && accept && bus.rx_eop) begin
            state <= IDLE;
          end
        end
        RECV: begin
          if (accept) begin
            if (bus.rx_sop) begin
              // The abort is reported for the old frame; a new frame that is
              // also a single sop+eop byte has no cycle left for its own
              // pulse and is simply discarded.
              drop       <= 1'b1;
              drop_cause <= CAUSE_ABORT;
              state      <= bus.rx_eop ? IDLE : RECV;
            end else if (count_nxt > MTU_CNT) begin
              drop       <= 1'b1;
              drop_cause <= CAUSE_MTU;
              state      <= bus.rx_eop ? IDLE : DISCARD;
            end else if (bus.rx_eop) begin
              if (count_nxt < MIN_CNT) begin
                drop       <= 1'b1;
                drop_cause <= CAUSE_RUNT;
                state      <= IDLE;
              end else if (class_nxt == CLS_TT && !tt_window) begin
                drop       <= 1'b1;
                drop_cause <= CAUSE_TTWIN;
                state      <= IDLE;
              end else begin
                desc_valid_q <= 1'b1;
                desc_class_q <= class_nxt;
                desc_len_q   <= len_nxt;
                state        <= DESC;
              end
            end
          end
        end
        DESC: begin
          if (bus.desc_ready) begin
            desc_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ingress_frame_classifier.sv
// ---------------------------------------------------------------------------
// tb_ingress_frame_classifier
// Purpose : self-checking bench for ingress_frame_classifier. Frames are
//           built in a byte buffer, streamed through the interface, and the
//           observed drops/descriptors are compared with a reference model
//           that classifies straight from the frame bytes and length.
// ---------------------------------------------------------------------------
module tb_ingress_frame_classifier;

  localparam int MIN_LEN = 64;
  localparam int MTU_LEN = 1520;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cur_state;
  logic       drop;
  logic [1:0] drop_cause;

  ingress_frame_classifier_if bus();

  ingress_frame_classifier dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cur_state  (cur_state),
    .drop       (drop),
    .drop_cause (drop_cause)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] fbuf [0:2047];
  int         tap_idx = -1;
  int         tap_cyc = -1;
  int         eop_cyc = -1;

  logic [1:0] drop_q [$];
  int         drop_cyc_q [$];
  logic [9:0] desc_q [$];
  int         desc_rise_cyc = -1;
  int         desc_hi_cnt = 0;
  logic       dv_prev = 1'b0;

  bit rand_ready = 1'b0;
  bit ready_force = 1'b1;

  // Free-running cycle counter used to time events against accepted bytes.
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream queue model: either always/never ready, or random ready.
  initial begin
    bus.desc_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.desc_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Event monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (drop) begin
      drop_q.push_back(drop_cause);
      drop_cyc_q.push_back(cyc);
    end
    if (bus.desc_valid && bus.desc_ready) begin
      desc_q.push_back({bus.desc_class, bus.desc_len});
    end
    if (bus.desc_valid && !dv_prev) desc_rise_cyc = cyc;
    if (bus.desc_valid) desc_hi_cnt = desc_hi_cnt + 1;
    dv_prev = bus.desc_valid;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearEvents();
    drop_q.delete();
    drop_cyc_q.delete();
    desc_q.delete();
    desc_hi_cnt = 0;
    desc_rise_cyc = -1;
  endtask

  // kind: 0 BE, 1 marker with tt bit set, 2 marker with tt bit clear,
  // 3 PCF EtherType that also carries the marker
  task automatic buildFrame(input int n, input int kind);
    logic [31:0] mk;
    mk = 32'hABADBABE;
    for (int i = 0; i < n; i++) fbuf[i] = 8'($urandom);
    if (kind == 0) begin
      fbuf[0] = 8'h02;
    end else begin
      fbuf[0] = mk[31:24];
      fbuf[1] = mk[23:16];
      fbuf[2] = mk[15:8];
      fbuf[3] = mk[7:0];
    end
    if (kind == 1) fbuf[4] = fbuf[4] | 8'h01;
    if (kind == 2) fbuf[4] = fbuf[4] & 8'hFE;
    if (kind == 3) begin
      fbuf[12] = 8'h89;
      fbuf[13] = 8'h1D;
    end else begin
      fbuf[12] = 8'h08;
      fbuf[13] = 8'h00;
    end
  endtask

  function automatic logic [1:0] modelClass(input int n);
    logic [31:0] dst;
    bit pcf, mk, tt;
    dst = {fbuf[0], fbuf[1], fbuf[2], fbuf[3]};
    pcf = (n >= 14) && (fbuf[12] == 8'h89) && (fbuf[13] == 8'h1D);
    mk  = (n >= 4) && (dst == 32'hABADBABE);
    tt  = (n >= 5) && fbuf[4][0];
    if (pcf) return 2'b00;
    if (mk) return tt ? 2'b01 : 2'b11;
    return 2'b10;
  endfunction

  // Streams fbuf[0..n-1] as one frame; cur_state equals st while the sop
  // byte is offered and is random afterwards.
  task automatic applyStimulus(input int n, input logic [1:0] st, input bit gaps, input bit with_eop);
    int idx;
    int stall;
    idx = 0;
    stall = 0;
    while (idx < n && stall < 400) begin
      @(posedge clk);
      #1;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.rx_valid = 1'b0;
        bus.rx_sop   = 1'($urandom);
        bus.rx_eop   = 1'($urandom);
        bus.rx_data  = 8'($urandom);
      end else begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = fbuf[idx];
        bus.rx_sop   = (idx == 0);
        bus.rx_eop   = with_eop && (idx == n - 1);
      end
      cur_state = (idx == 0) ? st : 2'($urandom_range(0, 3));
      @(negedge clk);
      if (bus.rx_valid && bus.rx_ready) begin
        if (idx == tap_idx) tap_cyc = cyc;
        if (idx == n - 1) eop_cyc = cyc;
        idx++;
        stall = 0;
      end else begin
        stall++;
      end
    end
    checkOutput("rx_accept", 32'(idx), 32'(n));
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_sop   = 1'b0;
    bus.rx_eop   = 1'b0;
  endtask

  // Reference outcome of a complete frame from its length, bytes and the
  // timetable window seen at sop.
  task automatic expectOutcome(input int n, input bit win, input string pfx);
    logic [1:0] cls;
    logic [1:0] cause;
    logic [7:0] len;
    bit is_drop;
    cls = modelClass(n);
    len = 8'((n + 15) / 16);
    cause = 2'b00;
    is_drop = 1'b1;
    if (n > MTU_LEN) cause = 2'b01;
    else if (n < MIN_LEN) cause = 2'b00;
    else if (cls == 2'b01 && !win) cause = 2'b10;
    else is_drop = 1'b0;
    for (int i = 0; i < 300 && drop_q.size() == 0 && desc_q.size() == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    if (is_drop) begin
      checkOutput({pfx, "_drop_count"}, 32'(drop_q.size()), 32'd1);
      if (drop_q.size() > 0) checkOutput({pfx, "_drop_cause"}, 32'(drop_q[0]), 32'(cause));
      checkOutput({pfx, "_no_desc"}, 32'(desc_q.size()), 32'd0);
    end else begin
      checkOutput({pfx, "_desc_count"}, 32'(desc_q.size()), 32'd1);
      if (desc_q.size() > 0) begin
        checkOutput({pfx, "_class"}, 32'(desc_q[0][9:8]), 32'(cls));
        checkOutput({pfx, "_len"}, 32'(desc_q[0][7:0]), 32'(len));
      end
      checkOutput({pfx, "_no_drop"}, 32'(drop_q.size()), 32'd0);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    cur_state    = 2'b00;
    bus.rx_valid = 1'b0;
    bus.rx_sop   = 1'b0;
    bus.rx_eop   = 1'b0;
    bus.rx_data  = 8'h00;
    ready_force  = 1'b1;
    rand_ready   = 1'b0;

    // Outputs while held in reset
    repeat (3) @(negedge clk);
    checkOutput("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    checkOutput("rst_desc_valid", 32'(bus.desc_valid), 32'd0);
    checkOutput("rst_desc_class", 32'(bus.desc_class), 32'd0);
    checkOutput("rst_desc_len", 32'(bus.desc_len), 32'd0);
    checkOutput("rst_drop", 32'(drop), 32'd0);
    checkOutput("rst_drop_cause", 32'(drop_cause), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 100-byte BE frame, descriptor one cycle after eop, single-cycle valid
    $display("[TB] BE frame, 100 bytes");
    buildFrame(100, 0);
    clearEvents();
    applyStimulus(100, 2'b00, 1'b0, 1'b1);
    expectOutcome(100, 1'b0, "be100");
    checkOutput("be100_valid_time", 32'(desc_rise_cyc), 32'(eop_cyc + 1));
    checkOutput("be100_valid_cycles", 32'(desc_hi_cnt), 32'd1);

    // TT frame inside and outside the TT window
    $display("[TB] TT frame, window open then closed");
    buildFrame(64, 1);
    clearEvents();
    applyStimulus(64, 2'b11, 1'b0, 1'b1);
    expectOutcome(64, 1'b1, "tt_open");
    buildFrame(64, 1);
    clearEvents();
    applyStimulus(64, 2'b00, 1'b0, 1'b1);
    expectOutcome(64, 1'b0, "tt_closed");

    // Oversize frame: drop right after the first byte past MTU
    $display("[TB] 1600-byte frame");
    buildFrame(1600, 0);
    clearEvents();
    tap_idx = MTU_LEN;
    applyStimulus(1600, 2'b00, 1'b0, 1'b1);
    tap_idx = -1;
    expectOutcome(1600, 1'b0, "mtu");
    if (drop_cyc_q.size() > 0) checkOutput("mtu_drop_time", 32'(drop_cyc_q[0]), 32'(tap_cyc + 1));
    checkOutput("mtu_idle_ready", 32'(bus.rx_ready), 32'd1);
    buildFrame(64, 2);
    clearEvents();
    applyStimulus(64, 2'b00, 1'b0, 1'b1);
    expectOutcome(64, 1'b0, "after_mtu");

    // MTU-sized PCF frame with a stalled descriptor queue
    $display("[TB] 1520-byte PCF frame with backpressure");
    ready_force = 1'b0;
    buildFrame(1520, 3);
    clearEvents();
    applyStimulus(1520, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !bus.desc_valid; i++) @(negedge clk);
    checkOutput("pcf_valid", 32'(bus.desc_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("pcf_hold%0d", i),
                  32'({bus.rx_ready, bus.desc_valid, bus.desc_class, bus.desc_len}),
                  32'({1'b0, 1'b1, 2'b00, 8'd95}));
      @(negedge clk);
    end
    ready_force = 1'b1;
    expectOutcome(1520, 1'b0, "pcf1520");

    // Abort by a new sop mid-frame, then the new frame completes
    $display("[TB] aborted frame followed by a new frame");
    buildFrame(80, 2);
    clearEvents();
    applyStimulus(30, 2'b01, 1'b0, 1'b0);
    buildFrame(80, 2);
    applyStimulus(80, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 50 && desc_q.size() == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("abort_drop_count", 32'(drop_q.size()), 32'd1);
    if (drop_q.size() > 0) checkOutput("abort_cause", 32'(drop_q[0]), 32'd3);
    checkOutput("abort_desc_count", 32'(desc_q.size()), 32'd1);
    if (desc_q.size() > 0) checkOutput("abort_new_desc", 32'(desc_q[0]), 32'({2'b11, 8'd5}));

    // Single sop+eop byte
    $display("[TB] 1-byte frame");
    buildFrame(1, 0);
    clearEvents();
    applyStimulus(1, 2'b00, 1'b0, 1'b1);
    expectOutcome(1, 1'b0, "one_byte");

    // Randomized frames, gaps on the byte stream and random queue readiness
    $display("[TB] randomized frames");
    rand_ready = 1'b1;
    for (int f = 0; f < 24; f++) begin
      int n;
      int kind;
      int cat;
      logic [1:0] st;
      cat = $urandom_range(0, 9);
      if (cat < 6) n = $urandom_range(1, 200);
      else if (cat < 8) n = $urandom_range(1500, 1530);
      else n = $urandom_range(60, 70);
      kind = $urandom_range(0, 3);
      st = 2'($urandom_range(0, 3));
      buildFrame(n, kind);
      clearEvents();
      applyStimulus(n, st, 1'b1, 1'b1);
      expectOutcome(n, st == 2'b11, $sformatf("rnd%0d", f));
    end
    rand_ready = 1'b0;
    ready_force = 1'b1;
    repeat (3) @(negedge clk);

    // Reset while a descriptor is pending
    $display("[TB] reset during a pending descriptor");
    ready_force = 1'b0;
    repeat (2) @(negedge clk);
    buildFrame(100, 0);
    clearEvents();
    applyStimulus(100, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !bus.desc_valid; i++) @(negedge clk);
    checkOutput("desc_pending", 32'(bus.desc_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_desc_valid", 32'(bus.desc_valid), 32'd0);
    checkOutput("arst_desc_class", 32'(bus.desc_class), 32'd0);
    checkOutput("arst_desc_len", 32'(bus.desc_len), 32'd0);
    checkOutput("arst_rx_ready", 32'(bus.rx_ready), 32'd1);
    checkOutput("arst_drop", 32'(drop), 32'd0);
    checkOutput("arst_drop_cause", 32'(drop_cause), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_force = 1'b1;
    repeat (2) @(negedge clk);
    buildFrame(72, 2);
    clearEvents();
    applyStimulus(72, 2'b10, 1'b0, 1'b1);
    expectOutcome(72, 1'b0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
